// File: rtl/qreg_skid.sv
// qreg_skid: flow-controlled pipeline register slice with a two-entry skid buffer.
//
// This slice carries N-bit words between two valid/ready stages and sustains one word per
// cycle. o_ready depends only on the registered state, so there is no combinational path
// from i_ready to o_ready. Because of that, a word can arrive in the same cycle that the
// downstream stalls. The skid register catches that word.
//
// Ports:
//   i_clk    in   1   clock; all state updates on the rising edge
//   i_rst    in   1   synchronous active-high reset
//   i_data   in   N   upstream data word
//   i_valid  in   1   upstream word valid
//   o_ready  out  1   slice can accept a word (registered state only)
//   o_data   out  N   downstream data word (main register)
//   o_valid  out  1   downstream word valid
//   i_ready  in   1   downstream accepts o_data
//   o_occ    out  2   words held: 0, 1 or 2
//   o_beats  out  CW  words delivered downstream since reset, wraps modulo 2^CW
//
// The main and skid data registers are not reset. o_data is don't-care while o_valid is 0.
// Control decisions never look at i_data, so X on the data path cannot reach a control
// output.

module qreg_skid #(
    parameter int unsigned N  = 1,
    parameter int unsigned CW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_data,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [N-1:0]  o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [1:0]    o_occ,
    output logic [CW-1:0] o_beats
);

    // Occupancy states: StBusy means main valid; StFull means main and skid valid.
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  main_q, main_d;
    logic [N-1:0]  skid_q, skid_d;
    logic [CW-1:0] beats_q, beats_d;

    logic in_fire;
    logic out_fire;

    // ------------------------------------------------------------------
    // Outputs: decoded from the state register only.
    // ------------------------------------------------------------------
    always_comb begin
        o_valid = 1'b0;
        o_ready = 1'b1;
        o_occ   = 2'd0;
        unique case (state_q)
            StEmpty: begin
                o_valid = 1'b0;
                o_ready = 1'b1;
                o_occ   = 2'd0;
            end
            StBusy: begin
                o_valid = 1'b1;
                o_ready = 1'b1;
                o_occ   = 2'd1;
            end
            StFull: begin
                o_valid = 1'b1;
                o_ready = 1'b0;
                o_occ   = 2'd2;
            end
            default: begin
                o_valid = 1'b0;
                o_ready = 1'b1;
                o_occ   = 2'd0;
            end
        endcase
    end

    assign o_data  = main_q;
    assign o_beats = beats_q;

    assign in_fire  = i_valid & o_ready;
    assign out_fire = o_valid & i_ready;

    // ------------------------------------------------------------------
    // Next-state and data-path steering.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (in_fire) begin
                    main_d  = i_data;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (in_fire && out_fire) begin
                    // Head leaves as the new word arrives, so main is refilled directly.
                    main_d = i_data;
                end else if (in_fire) begin
                    // Downstream stalled while o_ready was already promised; park in skid.
                    skid_d  = i_data;
                    state_d = StFull;
                end else if (out_fire) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // o_ready is low here, so in_fire cannot occur.
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = StBusy;
                end
            end
            default: begin
                state_d = StEmpty;
            end
        endcase
    end

    always_comb begin
        beats_d = beats_q;
        if (out_fire) begin
            beats_d = beats_q + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Registers. Reset overrides any transfer in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StEmpty;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
        end
    end

    // Data registers carry no reset; their contents matter only while o_valid is 1.
    always_ff @(posedge i_clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

endmodule

// File: tb/tb_qreg_skid.sv
// Directed bench for qreg_skid. u_dut uses N=8 and the default CW=32. u_wrap shares the
// same inputs and uses CW=4, which exercises the wrap of the beat counter.

module tb_qreg_skid;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       valid;
    logic       ready;

    logic        d_ready, d_valid;
    logic [7:0]  d_data;
    logic [1:0]  d_occ;
    logic [31:0] d_beats;

    logic       w_ready, w_valid;
    logic [7:0] w_data;
    logic [1:0] w_occ;
    logic [3:0] w_beats;

    int n_vec;
    int n_err;

    qreg_skid #(.N(8), .CW(32)) u_dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_data  (din),
        .i_valid (valid),
        .o_ready (d_ready),
        .o_data  (d_data),
        .o_valid (d_valid),
        .i_ready (ready),
        .o_occ   (d_occ),
        .o_beats (d_beats)
    );

    qreg_skid #(.N(8), .CW(4)) u_wrap (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_data  (din),
        .i_valid (valid),
        .o_ready (w_ready),
        .o_data  (w_data),
        .o_valid (w_valid),
        .i_ready (ready),
        .o_occ   (w_occ),
        .o_beats (w_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are registered, so sampling 1 time unit after the edge shows post-edge state.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst   = 1'b1;
        valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        valid = 1'b0;
        ready = 1'b0;
        din   = 8'h00;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid[%0d]: got %b want 0", c, d_valid); end
            n_vec++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready[%0d]: got %b want 1", c, d_ready); end
            n_vec++; if (d_occ !== 2'd0) begin n_err++; $display("FAIL reset_occ[%0d]: got %0d want 0", c, d_occ); end
            n_vec++; if (d_beats !== 32'd0) begin n_err++; $display("FAIL reset_beats[%0d]: got %0d want 0", c, d_beats); end
            n_vec++; if (w_beats !== 4'd0) begin n_err++; $display("FAIL reset_wbeats[%0d]: got %0d want 0", c, w_beats); end
        end
        rst = 1'b0;
    endtask

    task automatic test_streaming;
        apply_reset();
        ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            valid = 1'b1;
            din   = 8'(k);
            tick();
            n_vec++; if (d_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", k, d_valid); end
            n_vec++; if (d_data !== 8'(k)) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", k, d_data, 8'(k)); end
            n_vec++; if (d_occ !== 2'd1) begin n_err++; $display("FAIL stream_occ[%0d]: got %0d want 1", k, d_occ); end
            n_vec++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %b want 1", k, d_ready); end
            n_vec++; if (d_beats !== 32'(k - 1)) begin n_err++; $display("FAIL stream_beats[%0d]: got %0d want %0d", k, d_beats, k - 1); end
        end
        valid = 1'b0;
        tick();
        n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain_valid: got %b want 0", d_valid); end
        n_vec++; if (d_beats !== 32'd16) begin n_err++; $display("FAIL stream_final_beats: got %0d want 16", d_beats); end
    endtask

    task automatic test_stall_skid;
        apply_reset();
        ready = 1'b1;
        valid = 1'b1;
        din   = 8'hA1;
        tick();
        n_vec++; if (d_data !== 8'hA1) begin n_err++; $display("FAIL skid_present_a1: got %h want a1", d_data); end
        // Downstream stalls just as 0xA2 arrives; 0xA2 must land in the skid register.
        ready = 1'b0;
        din   = 8'hA2;
        tick();
        n_vec++; if (d_occ !== 2'd2) begin n_err++; $display("FAIL skid_occ_full: got %0d want 2", d_occ); end
        n_vec++; if (d_ready !== 1'b0) begin n_err++; $display("FAIL skid_ready_low: got %b want 0", d_ready); end
        n_vec++; if (d_data !== 8'hA1) begin n_err++; $display("FAIL skid_hold_a1: got %h want a1", d_data); end
        din = 8'hA3;
        tick();
        n_vec++; if (d_occ !== 2'd2) begin n_err++; $display("FAIL skid_occ_hold: got %0d want 2", d_occ); end
        n_vec++; if (d_data !== 8'hA1 || d_valid !== 1'b1) begin n_err++; $display("FAIL skid_stable: got %h/%b want a1/1", d_data, d_valid); end
        ready = 1'b1;
        tick();
        n_vec++; if (d_data !== 8'hA2 || d_valid !== 1'b1) begin n_err++; $display("FAIL skid_order_a2: got %h/%b want a2/1", d_data, d_valid); end
        n_vec++; if (d_occ !== 2'd1) begin n_err++; $display("FAIL skid_occ_busy: got %0d want 1", d_occ); end
        tick();
        n_vec++; if (d_data !== 8'hA3 || d_valid !== 1'b1) begin n_err++; $display("FAIL skid_order_a3: got %h/%b want a3/1", d_data, d_valid); end
        valid = 1'b0;
        tick();
        n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL skid_drained: got %b want 0", d_valid); end
        n_vec++; if (d_beats !== 32'd3) begin n_err++; $display("FAIL skid_beats: got %0d want 3", d_beats); end
    endtask

    task automatic test_random;
        logic [7:0]  q[$];
        logic [7:0]  sent;
        logic [7:0]  junk;
        int unsigned exp_beats;
        logic        exp_in, exp_out;
        int          errs_before;
        apply_reset();
        exp_beats   = 0;
        errs_before = n_err;
        void'($urandom(32'd20240611));
        for (int i = 0; i < 1000; i++) begin
            valid = ($urandom_range(0, 3) != 0);
            ready = ($urandom_range(0, 2) != 0);
            sent  = 8'($urandom);
            // Data is X whenever it is not offered; control outputs must not care.
            din     = valid ? sent : 8'bx;
            exp_in  = valid && (q.size() < 2);
            exp_out = ready && (q.size() > 0);
            tick();
            if (exp_out) begin
                junk = q.pop_front();
                exp_beats++;
            end
            if (exp_in) q.push_back(sent);
            n_vec++; if (d_valid !== (q.size() > 0)) begin n_err++; $display("FAIL rand_valid[%0d]: got %b want %b", i, d_valid, q.size() > 0); end
            n_vec++; if (d_ready !== (q.size() < 2)) begin n_err++; $display("FAIL rand_ready[%0d]: got %b want %b", i, d_ready, q.size() < 2); end
            n_vec++; if (d_occ !== 2'(q.size())) begin n_err++; $display("FAIL rand_occ[%0d]: got %0d want %0d", i, d_occ, q.size()); end
            n_vec++; if (d_beats !== exp_beats) begin n_err++; $display("FAIL rand_beats[%0d]: got %0d want %0d", i, d_beats, exp_beats); end
            if (q.size() > 0) begin
                n_vec++; if (d_data !== q[0]) begin n_err++; $display("FAIL rand_data[%0d]: got %h want %h", i, d_data, q[0]); end
            end
            if (n_err - errs_before > 10) break;
        end
        valid = 1'b0;
    endtask

    task automatic test_wrap;
        apply_reset();
        ready = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            valid = 1'b1;
            din   = 8'(k + 8'h40);
            tick();
            n_vec++; if (w_data !== 8'(k + 8'h40)) begin n_err++; $display("FAIL wrap_data[%0d]: got %h want %h", k, w_data, 8'(k + 8'h40)); end
            n_vec++; if (w_beats !== 4'((k - 1) % 16)) begin n_err++; $display("FAIL wrap_beats[%0d]: got %0d want %0d", k, w_beats, (k - 1) % 16); end
        end
        valid = 1'b0;
        tick();
        n_vec++; if (w_beats !== 4'd1) begin n_err++; $display("FAIL wrap_final: got %0d want 1", w_beats); end
        n_vec++; if (d_beats !== 32'd17) begin n_err++; $display("FAIL wrap_wide_beats: got %0d want 17", d_beats); end
    endtask

    task automatic test_mid_reset;
        apply_reset();
        ready = 1'b0;
        valid = 1'b1;
        din   = 8'h55;
        tick();
        din = 8'h66;
        tick();
        n_vec++; if (d_occ !== 2'd2 || d_data !== 8'h55) begin n_err++; $display("FAIL midrst_full: got occ %0d data %h want 2/55", d_occ, d_data); end
        // Reset with an upstream offer and a downstream accept: both must be ignored.
        rst   = 1'b1;
        ready = 1'b1;
        din   = 8'h77;
        tick();
        rst   = 1'b0;
        valid = 1'b0;
        n_vec++; if (d_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", d_valid); end
        n_vec++; if (d_occ !== 2'd0) begin n_err++; $display("FAIL midrst_occ: got %0d want 0", d_occ); end
        n_vec++; if (d_beats !== 32'd0) begin n_err++; $display("FAIL midrst_beats: got %0d want 0", d_beats); end
        n_vec++; if (d_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %b want 1", d_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++; if (d_valid !== 1'b0 || d_beats !== 32'd0) begin n_err++; $display("FAIL midrst_after[%0d]: got %b/%0d want 0/0", c, d_valid, d_beats); end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        valid = 1'b0;
        ready = 1'b0;
        din   = 8'h00;
        test_reset();
        test_streaming();
        test_stall_skid();
        test_random();
        test_wrap();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
